pick_job_scheduler: RTL and testbench

- Buffers pick-and-place commands (x, y, z) received from uart_top in a small FIFO.
- Dispatches the commands one at a time to the arm/table sequencer using a start/done handshake.
- Releases uart_top by pulsing its clr input as soon as a command is captured, so new commands can arrive while a job is still running.
- Provides a per-job watchdog timeout, an abort/flush input, and sticky error flags.

---
 rtl/pick_job_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_pick_job_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pick_job_scheduler.sv
// pick_job_scheduler
//   Queues pick-and-place commands arriving from uart_top and hands them to
//   the arm/table sequencer one at a time.
//
//   Capture side : cmd_valid (level) + cmd_x/y/z in, cmd_clr pulse out.
//   Dispatch side: job_start pulse + job_x/y/z out, job_done pulse in.
//   Control      : abort (synchronous flush), rst_n (asynchronous, active-low).
//   Status       : busy, level (FIFO occupancy), overflow and timeout_err
//                  (both sticky until abort or reset).
module pick_job_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2,
  parameter int unsigned CLR_CYCLES = 20,
  parameter logic [31:0] TIMEOUT    = 32'd2_500_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [31:0]   cmd_x,
  input  logic [31:0]   cmd_y,
  input  logic [31:0]   cmd_z,
  output logic          cmd_clr,
  output logic          job_start,
  output logic [31:0]   job_x,
  output logic [31:0]   job_y,
  output logic [31:0]   job_z,
  input  logic          job_done,
  input  logic          abort,
  output logic          busy,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          timeout_err
);

  typedef enum logic [1:0] {C_IDLE, C_CLR, C_WAIT} cap_state_e;
  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_RUN} disp_state_e;

  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [31:0] CLR_LAST = 32'(CLR_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = TIMEOUT - 32'd1;

  // FIFO storage, entries packed as {z, y, x}
  logic [95:0]  mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         full, empty;
  logic         push, pop;
  logic         cap_hit;

  cap_state_e   cap_q, cap_d;
  disp_state_e  disp_q, disp_d;
  logic [31:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0]  timer_q, timer_d;
  logic         overflow_q, overflow_d;
  logic         timeout_q, timeout_d;
  logic [95:0]  job_q, job_d;

  // Pointers carry one extra wrap bit, so the difference is the occupancy.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // ---------------- Capture FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= C_IDLE;
      clr_cnt_q <= '0;
    end else begin
      cap_q     <= cap_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    cap_d     = cap_q;
    clr_cnt_d = clr_cnt_q;
    cap_hit   = 1'b0;
    case (cap_q)
      C_IDLE: begin
        if (cmd_valid) begin
          cap_hit   = 1'b1;
          cap_d     = C_CLR;
          clr_cnt_d = '0;
        end
      end
      C_CLR: begin
        clr_cnt_d = clr_cnt_q + 32'd1;
        if (clr_cnt_q == CLR_LAST) cap_d = C_WAIT;
      end
      C_WAIT: begin
        // uart_top may still hold valid; wait for it to drop so the same
        // command is never captured twice.
        if (!cmd_valid) cap_d = C_IDLE;
      end
      default: cap_d = C_IDLE;
    endcase
  end

  always_comb begin
    cmd_clr = (cap_q == C_CLR);
  end

  // ---------------- Dispatch FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q  <= D_IDLE;
      timer_q <= '0;
    end else begin
      disp_q  <= disp_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    disp_d    = disp_q;
    timer_d   = timer_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    case (disp_q)
      D_IDLE: begin
        if (!empty) begin
          pop    = 1'b1;
          disp_d = D_ISSUE;
        end
      end
      D_ISSUE: begin
        timer_d = '0;
        disp_d  = D_RUN;
      end
      D_RUN: begin
        // done wins over a timeout landing in the same cycle
        if (job_done) begin
          disp_d = D_IDLE;
        end else if (timer_q == TO_LAST) begin
          timeout_d = 1'b1;
          disp_d    = D_IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: disp_d = D_IDLE;
    endcase
    if (abort) begin
      disp_d    = D_IDLE;
      timer_d   = '0;
      timeout_d = 1'b0;
      pop       = 1'b0;
    end
  end

  always_comb begin
    job_start = (disp_q == D_ISSUE) && !abort;
    busy      = (disp_q != D_IDLE) || !empty;
  end

  // ---------------- FIFO / datapath ----------------
  assign push       = cap_hit && !full && !abort;
  assign overflow_d = abort ? 1'b0 : (overflow_q | (cap_hit & full));
  assign wr_ptr_d   = abort ? '0 : wr_ptr_q + (AW+1)'(push);
  assign rd_ptr_d   = abort ? '0 : rd_ptr_q + (AW+1)'(pop);
  // Head is read straight into the job register, so job_x/y/z hold still
  // from job_start until the next pop.
  assign job_d      = pop ? mem_q[rd_ptr_q[AW-1:0]] : job_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      job_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      job_q      <= job_d;
    end
  end

  // Storage has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_z, cmd_y, cmd_x};
  end

  assign job_x       = job_q[31:0];
  assign job_y       = job_q[63:32];
  assign job_z       = job_q[95:64];
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pick_job_scheduler.sv
module tb_pick_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        job_done = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cmd_x = '0, cmd_y = '0, cmd_z = '0;

  logic        cmd_clr, job_start, busy, overflow, timeout_err;
  logic [31:0] job_x, job_y, job_z;
  logic [2:0]  level;

  logic        t_cmd_clr, t_job_start, t_busy, t_overflow, t_timeout_err;
  logic [31:0] t_job_x, t_job_y, t_job_z;
  logic [2:0]  t_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [95:0] d;
  } obs_t;

  obs_t        obs_q[$];
  obs_t        obs_t_q[$];
  logic [95:0] exp_q[$];
  logic [95:0] exp_t_q[$];

  pick_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_clr(cmd_clr),
    .job_start(job_start), .job_x(job_x), .job_y(job_y), .job_z(job_z),
    .job_done(job_done), .abort(abort), .busy(busy), .level(level),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  pick_job_scheduler #(.TIMEOUT(32'd50)) dut_to (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z), .cmd_clr(t_cmd_clr),
    .job_start(t_job_start), .job_x(t_job_x), .job_y(t_job_y), .job_z(t_job_z),
    .job_done(job_done), .abort(abort), .busy(t_busy), .level(t_level),
    .overflow(t_overflow), .timeout_err(t_timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every job_start with its cycle number; tasks compare later.
  always @(negedge clk) begin
    obs_t o;
    if (job_start === 1'b1) begin
      o.cyc = cyc;
      o.d   = {job_z, job_y, job_x};
      obs_q.push_back(o);
    end
  end

  always @(negedge clk) begin
    obs_t o;
    if (t_job_start === 1'b1) begin
      o.cyc = cyc;
      o.d   = {t_job_z, t_job_y, t_job_x};
      obs_t_q.push_back(o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input bit accept, output bit clr_ok);
    int n;
    cmd_x = x; cmd_y = y; cmd_z = z; cmd_valid = 1'b1;
    if (accept) exp_q.push_back({z, y, x});
    n = 0;
    while (cmd_clr !== 1'b1 && n < 10) begin tick(); n++; end
    clr_ok = (cmd_clr === 1'b1);
    cmd_valid = 1'b0;
    n = 0;
    while (cmd_clr === 1'b1 && n < 30) begin tick(); n++; end
    tick();
  endtask

  task automatic cleanup();
    cmd_valid = 1'b0; job_done = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0; tick();
    exp_q.delete(); exp_t_q.delete(); obs_q.delete(); obs_t_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({cmd_clr, job_start, busy, overflow, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {cmd_clr, job_start, busy, overflow, timeout_err});
    end
    checks++;
    if (level !== 3'd0 || {job_z, job_y, job_x} !== 96'd0) begin
      errors++; $display("FAIL reset_data got level=%0d job=%h exp=0", level, {job_z, job_y, job_x});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input string tag);
    int base, clr_n, clr_first;
    obs_t o;
    logic [95:0] e;
    base = cyc; clr_n = 0; clr_first = -1;
    cmd_x = 32'h0007_6666; cmd_y = 32'h0012_0000; cmd_z = 32'h0000_0100;
    cmd_valid = 1'b1;
    exp_q.push_back({32'h0000_0100, 32'h0012_0000, 32'h0007_6666});
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (cmd_clr === 1'b1) begin
        clr_n++;
        if (clr_first < 0) clr_first = k;
      end
      if (k == 1) begin
        checks++;
        if (level !== 3'd1) begin errors++; $display("FAIL %s level_c1 got=%0d exp=1", tag, level); end
      end
      if (k == 2) begin
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL %s level_c2 got=%0d exp=0", tag, level); end
      end
      if (k == 3) cmd_valid = 1'b0;
    end
    checks++;
    if (clr_n !== 20) begin errors++; $display("FAIL %s clr_width got=%0d exp=20", tag, clr_n); end
    checks++;
    if (clr_first !== 1) begin errors++; $display("FAIL %s clr_first got=%0d exp=1", tag, clr_first); end
    checks++;
    if (obs_q.size() !== 1) begin
      errors++; $display("FAIL %s start_count got=%0d exp=1", tag, obs_q.size());
    end
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.cyc !== base + 2) begin errors++; $display("FAIL %s start_cycle got=%0d exp=%0d", tag, o.cyc - base, 2); end
      checks++;
      if (o.d !== e) begin errors++; $display("FAIL %s job_data got=%h exp=%h", tag, o.d, e); end
    end
    job_done = 1'b1; tick(); job_done = 1'b0; tick(); tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after_done got=%b exp=0", tag, busy); end
    cleanup();
  endtask

  task automatic test_burst();
    bit ok;
    int c;
    obs_t o;
    logic [95:0] e;
    cleanup();
    for (int i = 1; i <= 5; i++)
      send_cmd(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i), 1'b1, ok);
    checks++;
    if (level !== 3'd4) begin errors++; $display("FAIL burst_level_full got=%0d exp=4", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow_pre got=%b exp=0", overflow); end
    send_cmd(32'h1000_0006, 32'h2000_0006, 32'h3000_0006, 1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_clr_on_drop got=0 exp=1"); end
    checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      errors++; $display("FAIL burst_overflow got ovf=%b level=%0d exp ovf=1 level=4", overflow, level);
    end
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL burst_first_start got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.d !== e) begin errors++; $display("FAIL burst_job1 got=%h exp=%h", o.d, e); end
    end
    obs_q.delete();
    for (int j = 2; j <= 4; j++) begin
      c = cyc;
      job_done = 1'b1; tick(); job_done = 1'b0;
      tick(); tick(); tick(); tick();
      checks++;
      if (obs_q.size() !== 1) begin
        errors++; $display("FAIL burst_start_%0d got=%0d starts exp=1", j, obs_q.size());
      end
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (o.cyc !== c + 2) begin errors++; $display("FAIL burst_b2b_%0d got=%0d exp=2", j, o.cyc - c); end
        checks++;
        if (o.d !== e) begin errors++; $display("FAIL burst_job%0d got=%h exp=%h", j, o.d, e); end
      end
      obs_q.delete();
    end
    cleanup();
  endtask

  task automatic test_hold();
    bit ok;
    int clr_n;
    obs_t o;
    logic [95:0] e;
    cleanup();
    send_cmd(32'hAAAA_0001, 32'hBBBB_0001, 32'hCCCC_0001, 1'b1, ok);
    cmd_x = 32'hAAAA_0002; cmd_y = 32'hBBBB_0002; cmd_z = 32'hCCCC_0002;
    cmd_valid = 1'b1;
    exp_q.push_back({32'hCCCC_0002, 32'hBBBB_0002, 32'hAAAA_0002});
    clr_n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (cmd_clr === 1'b1) clr_n++;
    end
    checks++;
    if (clr_n !== 20) begin errors++; $display("FAIL hold_clr got=%0d exp=20", clr_n); end
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL hold_level got=%0d exp=1", level); end
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL hold_level_drop got=%0d exp=1", level); end
    send_cmd(32'hAAAA_0003, 32'hBBBB_0003, 32'hCCCC_0003, 1'b1, ok);
    checks++;
    if (level !== 3'd2) begin errors++; $display("FAIL hold_recapture got=%0d exp=2", level); end
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL hold_starts got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.d !== e) begin errors++; $display("FAIL hold_job got=%h exp=%h", o.d, e); end
    end
    cleanup();
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    obs_t o;
    logic [95:0] e;
    cleanup();
    base = cyc;
    exp_t_q.push_back({32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1});
    send_cmd(32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, 1'b1, ok);
    exp_t_q.push_back({32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1});
    send_cmd(32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3, 1'b1, ok);
    while (cyc < base + 52) tick();
    checks++;
    if (t_timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", t_timeout_err); end
    tick();
    checks++;
    if (t_timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got=%b exp=1", t_timeout_err); end
    tick(); tick();
    checks++;
    if (obs_t_q.size() !== 2) begin errors++; $display("FAIL to_starts got=%0d exp=2", obs_t_q.size()); end
    for (int j = 0; j < 2; j++) begin
      if (obs_t_q.size() > 0 && exp_t_q.size() > 0) begin
        o = obs_t_q.pop_front(); e = exp_t_q.pop_front();
        checks++;
        if (o.cyc !== base + 2 + 52 * j) begin
          errors++; $display("FAIL to_start_cycle_%0d got=%0d exp=%0d", j, o.cyc - base, 2 + 52 * j);
        end
        checks++;
        if (o.d !== e) begin errors++; $display("FAIL to_job_%0d got=%h exp=%h", j, o.d, e); end
      end
    end
    cleanup();
  endtask

  task automatic test_abort();
    bit ok;
    obs_t o;
    logic [95:0] e;
    cleanup();
    for (int i = 1; i <= 6; i++)
      send_cmd(32'h0500_0000 + 32'(i), 32'h0600_0000 + 32'(i), 32'h0700_0000 + 32'(i), i <= 5, ok);
    job_done = 1'b1; tick(); job_done = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (level !== 3'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre got level=%0d busy=%b exp level=3 busy=1", level, busy);
    end
    checks++;
    if (overflow !== 1'b1 || t_timeout_err !== 1'b1) begin
      errors++; $display("FAIL abort_pre_flags got ovf=%b to=%b exp=1 1", overflow, t_timeout_err);
    end
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL abort_pre_starts got=%0d exp=2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.d !== e) begin errors++; $display("FAIL abort_pre_job got=%h exp=%h", o.d, e); end
    end
    obs_q.delete();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (level !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_flush got level=%0d busy=%b exp level=0 busy=0", level, busy);
    end
    checks++;
    if (overflow !== 1'b0 || t_timeout_err !== 1'b0) begin
      errors++; $display("FAIL abort_flags got ovf=%b to=%b exp=0 0", overflow, t_timeout_err);
    end
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL abort_no_start got=%0d exp=0", obs_q.size()); end
    cleanup();
  endtask

  task automatic test_reset_mid();
    bit ok;
    cleanup();
    send_cmd(32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 1'b1, ok);
    cmd_x = 32'h44; cmd_y = 32'h55; cmd_z = 32'h66; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (busy !== 1'b1 || cmd_clr !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got busy=%b clr=%b exp=1 1", busy, cmd_clr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_clr, job_start, busy, overflow, timeout_err} !== 5'b0 || level !== 3'd0) begin
      errors++; $display("FAIL rst_mid_async got flags=%b level=%0d exp=0", {cmd_clr, job_start, busy, overflow, timeout_err}, level);
    end
    checks++;
    if ({job_z, job_y, job_x} !== 96'd0) begin
      errors++; $display("FAIL rst_mid_job got=%h exp=0", {job_z, job_y, job_x});
    end
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete(); exp_t_q.delete(); obs_q.delete(); obs_t_q.delete();
    test_single("after_reset");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_burst();
    test_hold();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
